pwr_relay_sequencer: RTL and testbench

Sequences the four power relays (GND plus rails 1-3) toward the relay pattern requested by the I2C relay register. It applies one relay change per step, with a programmable tick-based delay between steps. Power-up order is GND, rail1, rail2, rail3; power-down order is the reverse. An active-low alert trips all relays off immediately and the block stays tripped until cleared. It sits between the I2C relay register / overload-alert logic and the PWR_x relay drivers.

---
 rtl/pwr_relay_sequencer_pkg.sv | 20 ++
 rtl/pwr_relay_sequencer_step_select.sv | 53 +++++
 rtl/pwr_relay_sequencer.sv | 112 +++++++++++
 tb/tb_pwr_relay_sequencer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwr_relay_sequencer_pkg.sv
// Shared definitions for the power relay sequencer: FSM state encoding,
// relay bit positions and the default step-delay width.
package pwr_relay_sequencer_pkg;

    // Sequencer states; the encoding is also exposed on the debug port.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_TRIP = 2'd2
    } state_t;

    // Relay bit map shared by req and pwr.
    localparam int RAIL1      = 0;
    localparam int RAIL2      = 1;
    localparam int RAIL3      = 2;
    localparam int GND_BIT    = 3;
    localparam int N_RAIL_DEF = 3;
    localparam int DLY_W_DEF  = 8;

endpackage

// File: rtl/pwr_relay_sequencer_step_select.sv
// Combinational next-change picker. Given the present relay state and the
// effective target, it selects the single relay to toggle next:
//   1. highest rail that must turn off
//   2. GND on when the target wants it
//   3. GND off once all rails are off
//   4. lowest rail that must turn on
// chg_mask is one-hot (or zero when pwr already equals tgt).
module pwr_step_select
    import pwr_relay_sequencer_pkg::*;
#(
    parameter int N_RAIL = N_RAIL_DEF
) (
    input  logic [N_RAIL:0] pwr_i,
    input  logic [N_RAIL:0] tgt_i,
    output logic [N_RAIL:0] chg_mask_o,
    output logic            chg_valid_o
);

    logic [N_RAIL-1:0] off_m;
    logic [N_RAIL-1:0] on_m;

    assign off_m = pwr_i[N_RAIL-1:0] & ~tgt_i[N_RAIL-1:0];
    assign on_m  = tgt_i[N_RAIL-1:0] & ~pwr_i[N_RAIL-1:0];

    // Priority pick of the one relay that changes on the next step.
    always_comb begin
        chg_mask_o = '0;
        if (|off_m) begin
            // Ascending scan: the last hit is the highest-index rail.
            for (int i = 0; i < N_RAIL; i++) begin
                if (off_m[i]) begin
                    chg_mask_o    = '0;
                    chg_mask_o[i] = 1'b1;
                end
            end
        end else if (tgt_i[N_RAIL] && !pwr_i[N_RAIL]) begin
            chg_mask_o[N_RAIL] = 1'b1;
        end else if (!tgt_i[N_RAIL] && pwr_i[N_RAIL] && (pwr_i[N_RAIL-1:0] == '0)) begin
            chg_mask_o[N_RAIL] = 1'b1;
        end else if (|on_m) begin
            // Descending scan: the last hit is the lowest-index rail.
            for (int i = N_RAIL - 1; i >= 0; i--) begin
                if (on_m[i]) begin
                    chg_mask_o    = '0;
                    chg_mask_o[i] = 1'b1;
                end
            end
        end
    end

    assign chg_valid_o = |chg_mask_o;

endmodule

// File: rtl/pwr_relay_sequencer.sv
// Power relay sequencer: walks the GND + rail relays one change at a time
// toward the requested pattern, waiting step_dly ticks after each change.
// Power-up order GND, rail1..3; power-down is the reverse. alert_n low trips
// every relay off at once.
// Optional macro PWR_SEQ_TRIP_LATCH_EN: when defined, TRIP is left only by a
// clr_fault pulse with alert_n high; otherwise TRIP is left once alert_n is
// high and the effective target is all-off, and clr_fault is ignored.
module pwr_relay_sequencer
    import pwr_relay_sequencer_pkg::*;
#(
    parameter int DLY_W  = DLY_W_DEF,
    parameter int N_RAIL = N_RAIL_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_RAIL:0]   req,
    input  logic [DLY_W-1:0]  step_dly,
    input  logic              tick,
    input  logic              alert_n,
    input  logic              clr_fault,
    output logic [N_RAIL:0]   pwr,
    output logic              busy,
    output logic              fault,
    output logic [1:0]        dbg_state
);

    state_t            state_q;
    logic [N_RAIL:0]   pwr_q;
    logic [N_RAIL:0]   pwr_d;
    logic [DLY_W-1:0]  cnt_q;
    logic              fault_q;
    logic [N_RAIL:0]   tgt;
    logic [N_RAIL:0]   chg_mask;
    logic              chg_valid;

    // Rails are never energised without GND, so a request lacking GND means all-off.
    assign tgt = req[N_RAIL] ? req : '0;

    pwr_step_select #(
        .N_RAIL (N_RAIL)
    ) u_step_select (
        .pwr_i       (pwr_q),
        .tgt_i       (tgt),
        .chg_mask_o  (chg_mask),
        .chg_valid_o (chg_valid)
    );

    assign pwr_d = pwr_q ^ chg_mask;

`ifndef PWR_SEQ_TRIP_LATCH_EN
    logic unused_clr_fault;
    assign unused_clr_fault = clr_fault;
`endif

    // Sequencer FSM with the step-delay counter; a trip overrides everything.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pwr_q   <= '0;
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else if (!alert_n) begin
            state_q <= ST_TRIP;
            pwr_q   <= '0;
            cnt_q   <= '0;
            fault_q <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (chg_valid) begin
                        pwr_q <= pwr_d;
                        // step_dly is sampled here; a tick this cycle is not counted.
                        if (step_dly != '0) begin
                            cnt_q   <= step_dly;
                            state_q <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (tick && (cnt_q != '0)) begin
                        cnt_q <= cnt_q - DLY_W'(1);
                        if (cnt_q == DLY_W'(1)) begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_TRIP: begin
`ifdef PWR_SEQ_TRIP_LATCH_EN
                    if (clr_fault) begin
                        state_q <= ST_IDLE;
                        fault_q <= 1'b0;
                    end
`else
                    if (tgt == '0) begin
                        state_q <= ST_IDLE;
                        fault_q <= 1'b0;
                    end
`endif
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign pwr       = pwr_q;
    assign fault     = fault_q;
    assign busy      = (state_q != ST_IDLE) || (pwr_q != tgt);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_pwr_relay_sequencer.sv
// Bench for pwr_relay_sequencer: random ramps checked against a sequence-level
// reference model through an expected-step queue, plus directed trip/reset cases.
module tb_pwr_relay_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [7:0] step_dly;
  logic       tick;
  logic       alert_n;
  logic       clr_fault;
  logic [3:0] pwr;
  logic       busy;
  logic       fault;
  logic [1:0] dbg_state;

  pwr_relay_sequencer #(.DLY_W(8), .N_RAIL(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .step_dly  (step_dly),
    .tick      (tick),
    .alert_n   (alert_n),
    .clr_fault (clr_fault),
    .pwr       (pwr),
    .busy      (busy),
    .fault     (fault),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Expected step entry: [15] check spacing, [11:4] ticks between steps, [3:0] pwr.
  logic [15:0] exp_q[$];
  logic [3:0]  model_pwr;
  bit          mon_en;
  bit          tick_auto;
  int          tick_pct;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // ---------------- tick generator ----------------
  initial begin
    tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (tick_auto) tick = ($urandom_range(1, 100) <= tick_pct);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [3:0]  prev_pwr;
    logic [15:0] e;
    int          acc;
    logic        pend;
    logic        pend_prev;
    prev_pwr  = '0;
    acc       = 0;
    pend      = 1'b0;
    pend_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset || !mon_en) begin
        acc = 0;
      end else if (pwr !== prev_pwr) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_step: pwr=%b with no expected step at %0t", pwr, $time);
        end else begin
          e = exp_q.pop_front();
          check("seq_pwr", int'(pwr), int'(e[3:0]));
          if (e[15]) begin
            check("seq_ticks", acc, int'(e[11:4]));
            if (e[11:4] != 8'd0) check("last_tick_before_step", int'(pend_prev), 1);
          end
        end
        acc = 0;
      end else begin
        acc += int'(pend);
      end
      prev_pwr  = pwr;
      pend_prev = pend;
      pend      = tick;
    end
  end

  // ---------------- driver tasks ----------------
  // Reference: rails off highest-first, GND on if wanted, GND off last, rails on lowest-first.
  task automatic run_ramp(input logic [3:0] new_req, input int dly, input int pct);
    logic [3:0] tgt;
    logic [3:0] p;
    logic [3:0] steps[$];
    logic [7:0] d8;
    bit         done;
    tgt = new_req[3] ? new_req : 4'b0000;
    p   = model_pwr;
    d8  = 8'(dly);
    for (int r = 2; r >= 0; r--) if (p[r] && !tgt[r]) begin p[r] = 1'b0; steps.push_back(p); end
    if (tgt[3] && !p[3]) begin p[3] = 1'b1; steps.push_back(p); end
    if (!tgt[3] && p[3]) begin p[3] = 1'b0; steps.push_back(p); end
    for (int r = 0; r < 3; r++) if (!p[r] && tgt[r]) begin p[r] = 1'b1; steps.push_back(p); end
    foreach (steps[i]) exp_q.push_back({(i != 0), 3'b000, d8, steps[i]});
    @(posedge clk);
    #1;
    tick_pct = pct;
    step_dly = d8;
    req      = new_req;
    @(posedge clk);
    #1;
    if (steps.size() != 0) begin
      check("first_step_latency", int'(pwr), int'(steps[0]));
      if (dly != 0) check("busy_in_wait", int'(busy), 1);
    end else begin
      check("no_step_pwr", int'(pwr), int'(model_pwr));
      check("no_step_busy", int'(busy), 0);
    end
    done = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if (!busy) begin done = 1'b1; break; end
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL ramp_timeout: busy still 1, pwr=%b target=%b", pwr, tgt);
    end
    @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    check("final_pwr", int'(pwr), int'(tgt));
    check("final_fault", int'(fault), 0);
    exp_q.delete();
    model_pwr = tgt;
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    @(posedge clk);
    #1;
    tick = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset     = 1'b1;
    req       = '0;
    step_dly  = '0;
    alert_n   = 1'b1;
    clr_fault = 1'b0;
    mon_en    = 1'b0;
    tick_auto = 1'b1;
    tick_pct  = 50;
    model_pwr = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_pwr", int'(pwr), 0);
    check("reset_fault", int'(fault), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_state", int'(dbg_state), 0);
    reset  = 1'b0;
    mon_en = 1'b1;

    // Power-up with 5-tick spacing, power-down with 2, request without GND.
    run_ramp(4'b1111, 5, 100);
    run_ramp(4'b0000, 2, 60);
    run_ramp(4'b0111, 3, 60);
    repeat (4) begin
      @(negedge clk);
      check("no_gnd_pwr", int'(pwr), 0);
      check("no_gnd_busy", int'(busy), 0);
    end

    // Random ramps.
    for (int n = 0; n < 30; n++) begin
      run_ramp(4'($urandom_range(0, 15)), $urandom_range(0, 4), $urandom_range(20, 100));
    end
    run_ramp(4'b0000, 1, 100);

    // Trip in WAIT at pwr=1011, alert coincident with a tick.
    mon_en    = 1'b0;
    tick_auto = 1'b0;
    tick      = 1'b0;
    @(posedge clk);
    #1;
    step_dly = 8'd3;
    req      = 4'b1111;
    for (int c = 0; c < 40 && pwr != 4'b1011; c++) pulse_tick();
    check("trip_setup_pwr", int'(pwr), 4'b1011);
    check("trip_setup_busy", int'(busy), 1);
    tick    = 1'b1;
    alert_n = 1'b0;
    @(posedge clk);
    #1;
    tick = 1'b0;
    check("trip_pwr", int'(pwr), 0);
    check("trip_fault", int'(fault), 1);
    check("trip_busy", int'(busy), 1);
    alert_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("trip_hold_req_on", int'(fault), 1);
    check("trip_hold_pwr", int'(pwr), 0);
`ifdef PWR_SEQ_TRIP_LATCH_EN
    req = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    check("latch_hold_req_off", int'(fault), 1);
    alert_n   = 1'b0;
    clr_fault = 1'b1;
    @(posedge clk);
    #1;
    clr_fault = 1'b0;
    alert_n   = 1'b1;
    check("latch_clr_ignored", int'(fault), 1);
    step_dly  = 8'd0;
    req       = 4'b1111;
    clr_fault = 1'b1;
    @(posedge clk);
    #1;
    clr_fault = 1'b0;
    check("latch_clr_exit", int'(fault), 0);
    check("latch_clr_pwr", int'(pwr), 0);
    @(posedge clk); #1; check("reramp_1", int'(pwr), 4'b1000);
    @(posedge clk); #1; check("reramp_2", int'(pwr), 4'b1001);
    @(posedge clk); #1; check("reramp_3", int'(pwr), 4'b1011);
    @(posedge clk); #1; check("reramp_4", int'(pwr), 4'b1111);
    model_pwr = 4'b1111;
`else
    clr_fault = 1'b1;
    @(posedge clk);
    #1;
    clr_fault = 1'b0;
    check("clr_ignored", int'(fault), 1);
    req = 4'b0000;
    @(posedge clk);
    #1;
    check("trip_exit_fault", int'(fault), 0);
    check("trip_exit_state", int'(dbg_state), 0);
    check("trip_exit_busy", int'(busy), 0);
    model_pwr = 4'b0000;
`endif
    tick_auto = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
    run_ramp(4'b0000, 0, 50);

    // Zero-delay ramp on consecutive edges, then async reset mid-ramp.
    run_ramp(4'b1111, 0, 50);
    run_ramp(4'b0000, 0, 50);
    mon_en = 1'b0;
    @(posedge clk);
    #1;
    step_dly = 8'd0;
    req      = 4'b1111;
    @(posedge clk);
    #1;
    check("rst_ramp_1", int'(pwr), 4'b1000);
    @(posedge clk);
    #2;
    check("rst_ramp_2", int'(pwr), 4'b1001);
    reset = 1'b1;
    #1;
    check("async_reset_pwr", int'(pwr), 0);
    check("async_reset_state", int'(dbg_state), 0);
    check("async_reset_fault", int'(fault), 0);
    req = 4'b0000;
    @(posedge clk);
    #1;
    reset     = 1'b0;
    model_pwr = 4'b0000;
    @(negedge clk);
    mon_en = 1'b1;
    run_ramp(4'b1001, 2, 70);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
